// File: rtl/pla_t3_pkg.sv
// rtl/pla_t3_pkg.sv - shared constants and MISR step for the t3 PLA capture stage
package pla_t3_pkg;

    localparam int          Z_W      = 8;
    localparam int          SIG_W    = 16;
    localparam logic [15:0] SIG_SEED = 16'hFFFF;
    localparam logic [15:0] SIG_POLY = 16'h1021;

    // One MISR compaction step: shift, fold the feedback polynomial, inject data.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [Z_W-1:0]   data);
        logic [SIG_W-1:0] nxt;
        nxt = {s[SIG_W-2:0], 1'b0};
        if (s[SIG_W-1])
            nxt = nxt ^ SIG_POLY;
        nxt = nxt ^ {{(SIG_W-Z_W){1'b0}}, data};
        return nxt;
    endfunction

endpackage

// File: rtl/pla_t3_if.sv
// rtl/pla_t3_if.sv - handshake and status bundle between the PLA side, the capture stage and its consumer
interface pla_t3_if
    import pla_t3_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    logic [Z_W-1:0]         z_in;
    logic                   z_valid;
    logic                   z_ready;
    logic [Z_W-1:0]         out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] level;
    logic [SIG_W-1:0]       sig;
    logic [SIG_W-1:0]       count;
    logic                   clr_sig;

    modport master (
        output z_in, z_valid, out_ready, clr_sig,
        input  z_ready, out_data, out_valid, level, sig, count
    );

    modport slave (
        input  z_in, z_valid, out_ready, clr_sig,
        output z_ready, out_data, out_valid, level, sig, count
    );

endinterface

// File: rtl/pla_t3_fifo.sv
// rtl/pla_t3_fifo.sv - wrap-bit pointer FIFO holding captured PLA words
module pla_t3_fifo
    import pla_t3_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = Z_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [W-1:0]           wr_data,
    output logic                   wr_ready,
    output logic                   rd_valid,
    output logic [W-1:0]           rd_data,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = wr_valid && !full;
    assign pop   = rd_ready && !empty;

    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign level    = wr_ptr - rd_ptr;
    // Storage is not reset, so the head is masked while empty to give a clean 0x00.
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pla_t3_capture.sv
// rtl/pla_t3_capture.sv - PLA output capture stage with FIFO, MISR signature and accept counter
module pla_t3_capture
    import pla_t3_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pla_t3_if.slave  bus
);

    logic             accept;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] count_q;

    pla_t3_fifo #(
        .DEPTH (DEPTH),
        .W     (Z_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (bus.z_valid),
        .wr_data  (bus.z_in),
        .wr_ready (bus.z_ready),
        .rd_valid (bus.out_valid),
        .rd_data  (bus.out_data),
        .rd_ready (bus.out_ready),
        .level    (bus.level)
    );

    assign accept = bus.z_valid && bus.z_ready;

    // A clear coinciding with an accept restarts compaction from the seed with that word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q   <= SIG_SEED;
            count_q <= '0;
        end else if (bus.clr_sig) begin
            if (accept) begin
                sig_q   <= misr_step(SIG_SEED, bus.z_in);
                count_q <= {{(SIG_W-1){1'b0}}, 1'b1};
            end else begin
                sig_q   <= SIG_SEED;
                count_q <= '0;
            end
        end else if (accept) begin
            sig_q <= misr_step(sig_q, bus.z_in);
            if (count_q != {SIG_W{1'b1}})
                count_q <= count_q + 1'b1;
        end
    end

    assign bus.sig   = sig_q;
    assign bus.count = count_q;

endmodule
